// File: rtl/delay_timer_arbiter.sv
// rtl/delay_timer_arbiter.sv - round-robin owner arbitration for one shared delay timer

module delay_timer_arbiter #(
  parameter int NumRequesters = 4,
  parameter int TickWidth     = 8
) (
  input  logic                               Clock,
  input  logic                               ResetN,
  input  logic [NumRequesters-1:0]           Request,
  input  logic [NumRequesters*TickWidth-1:0] TickCount,
  input  logic                               Timeout,
  output logic                               StartDelay,
  output logic [NumRequesters-1:0]           Grant,
  output logic [NumRequesters-1:0]           Done,
  output logic                               Busy
);

  localparam int PtrW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NumRequesters - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [PtrW-1:0]        pointer, pointer_nxt;
  logic [PtrW-1:0]        owner, owner_nxt;
  logic [PtrW-1:0]        owner_inc;
  logic [TickWidth-1:0]   remaining, remaining_nxt;
  logic [TickWidth-1:0]   tick_arr [NumRequesters];
  logic                   pick_valid;
  logic [PtrW-1:0]        pick_idx;
  logic [PtrW-1:0]        cand;
  int                     sum;
  logic [NumRequesters-1:0] owner_onehot;

  // Unpack the per-client period counts so they can be indexed by owner.
  for (genvar g = 0; g < NumRequesters; g++) begin : g_tick
    assign tick_arr[g] = TickCount[g*TickWidth +: TickWidth];
  end

  // Next owner in round-robin order once the current one releases the timer.
  assign owner_inc    = (owner == LastIdx) ? '0 : owner + 1'b1;
  assign owner_onehot = NumRequesters'(1) << owner;

  // Round-robin pick: first set request scanning upward from pointer with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    sum        = 0;
    for (int i = 0; i < NumRequesters; i++) begin
      sum = int'(pointer) + i;
      if (sum >= NumRequesters) sum = sum - NumRequesters;
      cand = PtrW'(sum);
      if (!pick_valid && Request[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State and datapath registers; reset drops straight to idle with no Done.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= ST_IDLE;
      pointer   <= '0;
      owner     <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      pointer   <= pointer_nxt;
      owner     <= owner_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Next-state logic: arbitrate in idle, count timer periods in run, release after done.
  always_comb begin
    state_nxt     = state;
    pointer_nxt   = pointer;
    owner_nxt     = owner;
    remaining_nxt = remaining;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_nxt     = pick_idx;
          remaining_nxt = tick_arr[pick_idx];
          state_nxt     = (tick_arr[pick_idx] == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // A dropped request cancels the delay even if a period just expired.
        if (!Request[owner]) begin
          state_nxt   = ST_IDLE;
          pointer_nxt = owner_inc;
        end else if (Timeout) begin
          if (remaining == TickWidth'(1)) begin
            state_nxt = ST_DONE;
          end else begin
            remaining_nxt = remaining - 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nxt   = ST_IDLE;
        pointer_nxt = owner_inc;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs decode from state and owner registers only.
  always_comb begin
    StartDelay = 1'b0;
    Grant      = '0;
    Done       = '0;
    Busy       = 1'b0;
    case (state)
      ST_RUN: begin
        StartDelay = 1'b1;
        Grant      = owner_onehot;
        Busy       = 1'b1;
      end
      ST_DONE: begin
        Grant = owner_onehot;
        Done  = owner_onehot;
        Busy  = 1'b1;
      end
      default: begin
        StartDelay = 1'b0;
      end
    endcase
  end

endmodule
